// File: rtl/rgb_pipe_delay.sv
// Fixed-latency RGB/sync delay line: DEPTH ce-gated register stages carrying a
// pixel word {r,g,b,de,hs,vs}, plus a saturating fill counter that drives q_valid.

module rgb_pipe_stage #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] pix_d, pix_q;

  always_comb begin
    pix_d = pix_q;
    if (ce) pix_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) pix_q <= rst_val;
    else       pix_q <= pix_d;
  end

  assign q = pix_q;
endmodule

module rgb_pipe_delay #(
  parameter int COLOR_W     = 4,
  parameter int DEPTH       = 2,
  parameter int BLANK_BLACK = 1,
  parameter int SYNC_ACTIVE = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic [COLOR_W-1:0] d_r,
  input  logic [COLOR_W-1:0] d_g,
  input  logic [COLOR_W-1:0] d_b,
  input  logic               d_de,
  input  logic               d_hs,
  input  logic               d_vs,
  output logic [COLOR_W-1:0] q_r,
  output logic [COLOR_W-1:0] q_g,
  output logic [COLOR_W-1:0] q_b,
  output logic               q_de,
  output logic               q_hs,
  output logic               q_vs,
  output logic               q_valid
);
  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("rgb_pipe_delay: DEPTH=%0d outside legal range 1..16", DEPTH);
  end
  if (COLOR_W < 1 || COLOR_W > 8) begin : g_bad_color_w
    $error("rgb_pipe_delay: COLOR_W=%0d outside legal range 1..8", COLOR_W);
  end

  localparam int   PIX_W   = 3*COLOR_W + 3;
  localparam int   CNT_W   = $clog2(DEPTH + 1);
  localparam logic SYNC_IN = (SYNC_ACTIVE == 0) ? 1'b1 : 1'b0;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic               de;
    logic               hs;
    logic               vs;
  } pix_t;

  pix_t in_pix, rst_pix, out_pix;
  logic [DEPTH:0][PIX_W-1:0] chain;

  // Blanking happens before stage 0 so every stage holds exactly what leaves the block.
  always_comb begin
    in_pix    = '{r: d_r, g: d_g, b: d_b, de: d_de, hs: d_hs, vs: d_vs};
    if (BLANK_BLACK != 0 && !d_de) begin
      in_pix.r = '0;
      in_pix.g = '0;
      in_pix.b = '0;
    end
    rst_pix   = '{r: '0, g: '0, b: '0, de: 1'b0, hs: SYNC_IN, vs: SYNC_IN};
  end

  assign chain[0] = in_pix;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    rgb_pipe_stage #(.W(PIX_W)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .ce     (ce),
      .rst_val(rst_pix),
      .d      (chain[k]),
      .q      (chain[k+1])
    );
  end

  assign out_pix = pix_t'(chain[DEPTH]);
  assign q_r  = out_pix.r;
  assign q_g  = out_pix.g;
  assign q_b  = out_pix.b;
  assign q_de = out_pix.de;
  assign q_hs = out_pix.hs;
  assign q_vs = out_pix.vs;

  // Counts ce edges since reset, sticking at DEPTH once the pipe is primed.
  logic [CNT_W-1:0] fill_cnt_d, fill_cnt_q;

  always_comb begin
    fill_cnt_d = fill_cnt_q;
    if (ce && fill_cnt_q != CNT_W'(DEPTH)) fill_cnt_d = fill_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) fill_cnt_q <= '0;
    else       fill_cnt_q <= fill_cnt_d;
  end

  assign q_valid = (fill_cnt_q == CNT_W'(DEPTH));
endmodule

// File: tb/tb_rgb_pipe_delay.sv
// Drives four differently-configured delay lines with one shared stream and
// scoreboards each against a queue-based "pixel from DEPTH ce edges ago" model.

module tb_rgb_pipe_delay;
  localparam int ND = 4;
  localparam int CW [ND] = '{4, 8, 8, 4};
  localparam int DP [ND] = '{2, 1, 16, 4};
  localparam int BB [ND] = '{1, 0, 1, 0};
  localparam int SA [ND] = '{0, 1, 1, 0};

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       de;
    logic       hs;
    logic       vs;
    logic       valid;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       ce    = 1'b0;
  logic [7:0] d_r = '0, d_g = '0, d_b = '0;
  logic       d_de = 1'b0, d_hs = 1'b1, d_vs = 1'b1;

  logic [3:0] r0, g0, b0, r3, g3, b3;
  logic [7:0] r1, g1, b1, r2, g2, b2;
  logic [ND-1:0] de_o, hs_o, vs_o, vl_o;

  rgb_pipe_delay #(.COLOR_W(4), .DEPTH(2), .BLANK_BLACK(1), .SYNC_ACTIVE(0)) u0 (
    .clk(clk), .reset(reset), .ce(ce), .d_r(d_r[3:0]), .d_g(d_g[3:0]), .d_b(d_b[3:0]),
    .d_de(d_de), .d_hs(d_hs), .d_vs(d_vs), .q_r(r0), .q_g(g0), .q_b(b0),
    .q_de(de_o[0]), .q_hs(hs_o[0]), .q_vs(vs_o[0]), .q_valid(vl_o[0]));
  rgb_pipe_delay #(.COLOR_W(8), .DEPTH(1), .BLANK_BLACK(0), .SYNC_ACTIVE(1)) u1 (
    .clk(clk), .reset(reset), .ce(ce), .d_r(d_r), .d_g(d_g), .d_b(d_b),
    .d_de(d_de), .d_hs(d_hs), .d_vs(d_vs), .q_r(r1), .q_g(g1), .q_b(b1),
    .q_de(de_o[1]), .q_hs(hs_o[1]), .q_vs(vs_o[1]), .q_valid(vl_o[1]));
  rgb_pipe_delay #(.COLOR_W(8), .DEPTH(16), .BLANK_BLACK(1), .SYNC_ACTIVE(1)) u2 (
    .clk(clk), .reset(reset), .ce(ce), .d_r(d_r), .d_g(d_g), .d_b(d_b),
    .d_de(d_de), .d_hs(d_hs), .d_vs(d_vs), .q_r(r2), .q_g(g2), .q_b(b2),
    .q_de(de_o[2]), .q_hs(hs_o[2]), .q_vs(vs_o[2]), .q_valid(vl_o[2]));
  rgb_pipe_delay #(.COLOR_W(4), .DEPTH(4), .BLANK_BLACK(0), .SYNC_ACTIVE(0)) u3 (
    .clk(clk), .reset(reset), .ce(ce), .d_r(d_r[3:0]), .d_g(d_g[3:0]), .d_b(d_b[3:0]),
    .d_de(d_de), .d_hs(d_hs), .d_vs(d_vs), .q_r(r3), .q_g(g3), .q_b(b3),
    .q_de(de_o[3]), .q_hs(hs_o[3]), .q_vs(vs_o[3]), .q_valid(vl_o[3]));

  obs_t act [ND];
  always_comb begin
    act[0] = '{r: {4'h0, r0}, g: {4'h0, g0}, b: {4'h0, b0}, de: de_o[0], hs: hs_o[0], vs: vs_o[0], valid: vl_o[0]};
    act[1] = '{r: r1, g: g1, b: b1, de: de_o[1], hs: hs_o[1], vs: vs_o[1], valid: vl_o[1]};
    act[2] = '{r: r2, g: g2, b: b2, de: de_o[2], hs: hs_o[2], vs: vs_o[2], valid: vl_o[2]};
    act[3] = '{r: {4'h0, r3}, g: {4'h0, g3}, b: {4'h0, b3}, de: de_o[3], hs: hs_o[3], vs: vs_o[3], valid: vl_o[3]};
  end

  // Reference: the output is the pixel accepted DEPTH ce edges ago, or the
  // reset word until DEPTH ce edges have passed since the last reset.
  obs_t hist  [ND][$];
  obs_t exp_q [ND][$];
  int   fill  [ND];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   stim_done = 1'b0;

  task automatic model_edge(input int d);
    obs_t p, e;
    logic [7:0] m;
    logic inact;
    m = 8'((1 << CW[d]) - 1);
    inact = (SA[d] == 0);
    if (reset) begin
      hist[d].delete();
      fill[d] = 0;
    end else if (ce) begin
      p = '{r: d_r & m, g: d_g & m, b: d_b & m, de: d_de, hs: d_hs, vs: d_vs, valid: 1'b1};
      if (BB[d] != 0 && !d_de) begin
        p.r = 8'h00; p.g = 8'h00; p.b = 8'h00;
      end
      hist[d].push_back(p);
      if (hist[d].size() > DP[d]) void'(hist[d].pop_front());
      if (fill[d] < DP[d]) fill[d]++;
    end
    if (fill[d] >= DP[d]) e = hist[d][0];
    else e = '{r: 8'h00, g: 8'h00, b: 8'h00, de: 1'b0, hs: inact, vs: inact, valid: 1'b0};
    exp_q[d].push_back(e);
  endtask

  task automatic drive(input logic rst, input logic c, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic de, input logic hs, input logic vs);
    @(posedge clk);
    #2;
    reset = rst; ce = c; d_r = r; d_g = g; d_b = b; d_de = de; d_hs = hs; d_vs = vs;
    for (int d = 0; d < ND; d++) model_edge(d);
  endtask

  // Monitor: each edge presents one output word per DUT; compare it to the queued expectation.
  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < ND; d++) begin
        if (exp_q[d].size() != 0) begin
          e = exp_q[d].pop_front();
          checks++;
          if (act[d] !== e) begin
            errors++;
            $display("FAIL dut%0d cycle %0d: got r=%h g=%h b=%h de=%b hs=%b vs=%b valid=%b, required r=%h g=%h b=%h de=%b hs=%b vs=%b valid=%b",
                     d, cyc, act[d].r, act[d].g, act[d].b, act[d].de, act[d].hs, act[d].vs, act[d].valid,
                     e.r, e.g, e.b, e.de, e.hs, e.vs, e.valid);
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [7:0] r, g, b;
    for (int d = 0; d < ND; d++) fill[d] = 0;
    // Reset, then a known pixel followed by a ce-held stretch.
    drive(1, 1, 8'h77, 8'h77, 8'h77, 1, 0, 0);
    drive(1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 1);
    drive(0, 1, 8'h0A, 8'h05, 8'h03, 1, 1, 1);
    drive(0, 1, 8'h01, 8'h02, 8'h04, 1, 1, 0);
    drive(0, 0, 8'h11, 8'h22, 8'h33, 1, 0, 1);
    drive(0, 0, 8'h44, 8'h55, 8'h66, 0, 1, 0);
    drive(0, 1, 8'h21, 8'h43, 8'h65, 1, 0, 1);
    drive(0, 1, 8'h87, 8'hA9, 8'hCB, 1, 1, 1);
    // Blanked pixels: full-scale colour with de=0 and hs asserted low.
    for (int i = 0; i < 6; i++) drive(0, 1, 8'hFF, 8'hFF, 8'hFF, 0, 0, 1);
    // Long ce=1 run so the deepest pipe primes and its counter sits at saturation.
    for (int i = 0; i < 60; i++) begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      drive(0, 1, r, g, b, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    // Mid-stream reset while all pipes are full and streaming.
    drive(1, 1, 8'hEE, 8'hDD, 8'hCC, 1, 1, 1);
    for (int i = 0; i < 40; i++) drive(0, 1, 8'(i * 7), 8'(i * 13), 8'(i * 29), 1'(i), 1'(i >> 1), 1'(i >> 2));
    // Random stream with random ce and rare resets.
    for (int i = 0; i < 2500; i++) begin
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      drive(($urandom_range(0, 399) == 0), ($urandom_range(0, 99) < 65), r, g, b,
            1'($urandom), 1'($urandom), 1'($urandom));
    end
    stim_done = 1'b1;
  end

  initial begin : finisher
    int budget;
    wait (stim_done);
    budget = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    repeat (2) @(posedge clk);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (exp_q[d].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d: %0d expectations left, required 0", d, exp_q[d].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
